// File: rtl/aia_sync_pkg.sv
// Shared types for the AIA interrupt-input conditioner.
package aia_sync_pkg;

  // Per-channel interpretation of the debounced line.
  typedef enum logic [1:0] {
    LVL_HI    = 2'd0,
    LVL_LO    = 2'd1,
    EDGE_RISE = 2'd2,
    EDGE_FALL = 2'd3
  } src_mode_e;

  // Edge modes keep a sticky pending bit; level modes mirror the request.
  function automatic logic is_edge_mode(src_mode_e m);
    return m[1];
  endfunction

endpackage

// File: rtl/aia_irq_cond_chan.sv
// One interrupt input channel: synchronizer chain, consecutive-sample
// debounce, edge history, source-mode mux and pending bit.
module aia_irq_cond_chan
  import aia_sync_pkg::*;
#(
  parameter int unsigned NrLevels       = 2,
  parameter int unsigned DebounceCycles = 4,
  parameter int unsigned CntW           = $clog2(DebounceCycles + 1)
) (
  input  logic      i_clk,
  input  logic      i_rst,
  input  logic      data_i,
  input  src_mode_e mode_i,
  input  logic      clr_i,
  output logic      level_o,
  output logic      irq_o,
  output logic      pending_o
);

  localparam logic [CntW-1:0] CntMax = CntW'(DebounceCycles - 1);

  logic [NrLevels-1:0] sync_q;
  logic                synced;
  logic                stable_q, stable_d;
  logic                stable_hist_q;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic                pending_q, pending_d;
  logic                edge_cls_q;
  logic                edge_now;
  logic                rise, fall;
  logic                irq;

  assign synced   = sync_q[NrLevels-1];
  assign edge_now = is_edge_mode(mode_i);
  assign rise     = stable_q & ~stable_hist_q;
  assign fall     = ~stable_q & stable_hist_q;

  // Synchronizer shift chain; a depth of one is still a real flop.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      sync_q <= '0;
    end else begin
      sync_q[0] <= data_i;
      for (int k = 1; k < NrLevels; k++) sync_q[k] <= sync_q[k-1];
    end
  end

  // Debounce: accept a new value only after DebounceCycles consecutive
  // differing samples; any agreeing sample restarts the count.
  always_comb begin
    stable_d = stable_q;
    cnt_d    = '0;
    if (synced != stable_q) begin
      if (cnt_q == CntMax) begin
        stable_d = synced;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Source-mode interpretation of the debounced line.
  always_comb begin
    irq = 1'b0;
    case (mode_i)
      LVL_HI:    irq = stable_q;
      LVL_LO:    irq = ~stable_q;
      EDGE_RISE: irq = rise;
      EDGE_FALL: irq = fall;
      default:   irq = 1'b0;
    endcase
  end

  // Pending: mirrors the request in level modes; sticky with set-over-clear
  // in edge modes. Crossing between mode classes drops stale pending state.
  always_comb begin
    pending_d = pending_q;
    if (!edge_now || (edge_now != edge_cls_q)) begin
      pending_d = irq;
    end else if (irq) begin
      pending_d = 1'b1;
    end else if (clr_i) begin
      pending_d = 1'b0;
    end
  end

  // State registers for debounce, history, pending and mode class.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      stable_q      <= 1'b0;
      stable_hist_q <= 1'b0;
      cnt_q         <= '0;
      pending_q     <= 1'b0;
      edge_cls_q    <= 1'b0;
    end else begin
      stable_q      <= stable_d;
      stable_hist_q <= stable_q;
      cnt_q         <= cnt_d;
      pending_q     <= pending_d;
      edge_cls_q    <= edge_now;
    end
  end

  assign level_o   = stable_q;
  assign irq_o     = irq;
  assign pending_o = pending_q;

endmodule

// File: rtl/aia_irq_input_conditioner.sv
// Array of independent interrupt input channels feeding the AIA gateways.
module aia_irq_input_conditioner
  import aia_sync_pkg::*;
#(
  parameter int unsigned NrChannels     = 32,
  parameter int unsigned NrLevels       = 2,
  parameter int unsigned DebounceCycles = 4
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic [NrChannels-1:0]      data_i,
  input  logic [NrChannels-1:0][1:0] mode_i,
  input  logic [NrChannels-1:0]      clr_i,
  output logic [NrChannels-1:0]      level_o,
  output logic [NrChannels-1:0]      irq_o,
  output logic [NrChannels-1:0]      pending_o
);

  localparam int unsigned CntW = $clog2(DebounceCycles + 1);

  // One conditioner per channel; no logic at this level.
  for (genvar g = 0; g < NrChannels; g++) begin : g_chan
    aia_irq_cond_chan #(
      .NrLevels       (NrLevels),
      .DebounceCycles (DebounceCycles),
      .CntW           (CntW)
    ) u_chan (
      .i_clk     (i_clk),
      .i_rst     (i_rst),
      .data_i    (data_i[g]),
      .mode_i    (src_mode_e'(mode_i[g])),
      .clr_i     (clr_i[g]),
      .level_o   (level_o[g]),
      .irq_o     (irq_o[g]),
      .pending_o (pending_o[g])
    );
  end

endmodule

// File: tb/tb_aia_irq_input_conditioner.sv
// Directed bench: wide instance (8 ch, 2 sync levels, 3-cycle debounce) and
// a minimal instance (1 ch, 1 level, 1-cycle debounce).
module tb_aia_irq_input_conditioner;
  import aia_sync_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst;
  logic [7:0]      data, clr, level, irq, pend;
  logic [7:0][1:0] mode;

  logic            b_data, b_clr, b_level, b_irq, b_pend;
  logic [0:0][1:0] b_mode;

  aia_irq_input_conditioner #(
    .NrChannels(8), .NrLevels(2), .DebounceCycles(3)
  ) dut_a (
    .i_clk(clk), .i_rst(rst), .data_i(data), .mode_i(mode), .clr_i(clr),
    .level_o(level), .irq_o(irq), .pending_o(pend)
  );

  aia_irq_input_conditioner #(
    .NrChannels(1), .NrLevels(1), .DebounceCycles(1)
  ) dut_b (
    .i_clk(clk), .i_rst(rst), .data_i(b_data), .mode_i(b_mode), .clr_i(b_clr),
    .level_o(b_level), .irq_o(b_irq), .pending_o(b_pend)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0] data;
    logic [7:0] clr;
    logic [7:0] lvl;
    logic [7:0] irq;
    logic [7:0] pend;
  } vec_t;

  vec_t tbl [16];

  function automatic vec_t mk(logic [7:0] d, logic [7:0] c, logic [7:0] l, logic [7:0] p);
    vec_t v;
    v.data = d; v.clr = c; v.lvl = l; v.irq = l | 8'h02; v.pend = p;
    return v;
  endfunction

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  int pulses;
  logic h0, h1, h2, mp, last_irq, e_irq;

  initial begin
    // ch0/ch3 LVL_HI exercised, ch1 LVL_LO, ch2 EDGE_FALL; rows are edges E1..E16
    tbl[0]  = mk(8'h09, 8'h00, 8'h00, 8'h02);
    tbl[1]  = mk(8'h09, 8'h00, 8'h00, 8'h02);
    tbl[2]  = mk(8'h01, 8'h00, 8'h00, 8'h02);
    tbl[3]  = mk(8'h01, 8'h00, 8'h00, 8'h02);
    tbl[4]  = mk(8'h01, 8'h00, 8'h01, 8'h02);
    tbl[5]  = mk(8'h01, 8'h00, 8'h01, 8'h03);
    tbl[6]  = mk(8'h01, 8'h00, 8'h01, 8'h03);
    tbl[7]  = mk(8'h09, 8'h03, 8'h01, 8'h03);
    tbl[8]  = mk(8'h08, 8'h00, 8'h01, 8'h03);
    tbl[9]  = mk(8'h08, 8'h00, 8'h01, 8'h03);
    tbl[10] = mk(8'h00, 8'h00, 8'h01, 8'h03);
    tbl[11] = mk(8'h00, 8'h00, 8'h09, 8'h03);
    tbl[12] = mk(8'h00, 8'h00, 8'h08, 8'h0B);
    tbl[13] = mk(8'h00, 8'h00, 8'h08, 8'h0A);
    tbl[14] = mk(8'h00, 8'h00, 8'h00, 8'h0A);
    tbl[15] = mk(8'h00, 8'h00, 8'h00, 8'h02);

    rst = 1'b1; data = '0; clr = '0;
    for (int i = 0; i < 8; i++) mode[i] = LVL_HI;
    mode[1] = LVL_LO;
    mode[2] = EDGE_FALL;
    b_data = 1'b0; b_clr = 1'b0; b_mode[0] = EDGE_RISE;
    step();
    step();
    chk("reset_level", level, 8'h00);
    chk("reset_irq", irq, 8'h02);
    chk("reset_pend", pend, 8'h00);
    chk("reset_b_level", 8'(b_level), 8'h00);
    rst = 1'b0;

    // latency, glitch rejection, exact 3-cycle acceptance, level-mode clear ignored
    for (int r = 0; r < 16; r++) begin
      data = tbl[r].data;
      clr  = tbl[r].clr;
      step();
      chk($sformatf("tbl%0d_level", r + 1), level, tbl[r].lvl);
      chk($sformatf("tbl%0d_irq", r + 1), irq, tbl[r].irq);
      chk($sformatf("tbl%0d_pend", r + 1), pend, tbl[r].pend);
    end
    clr = '0;

    // rising edge on ch5: single pulse, sticky pending, clear, set-beats-clear
    mode[5] = EDGE_RISE;
    step();
    chk("rise_modechg_irq", 8'(irq[5]), 8'h00);
    chk("rise_modechg_pend", 8'(pend[5]), 8'h00);
    data[5] = 1'b1;
    for (int s = 1; s <= 4; s++) begin
      step();
      chk($sformatf("rise_pre%0d_irq", s), 8'(irq[5]), 8'h00);
    end
    step();
    chk("rise_pulse_irq", 8'(irq[5]), 8'h01);
    chk("rise_pulse_pend", 8'(pend[5]), 8'h00);
    step();
    chk("rise_after_irq", 8'(irq[5]), 8'h00);
    chk("rise_after_pend", 8'(pend[5]), 8'h01);
    pulses = 0;
    for (int s = 0; s < 5; s++) begin
      step();
      if (irq[5]) pulses++;
    end
    chk("rise_sticky_pend", 8'(pend[5]), 8'h01);
    chk("rise_single_pulse", 8'(pulses), 8'h00);
    clr[5] = 1'b1;
    step();
    clr[5] = 1'b0;
    chk("rise_clr_pend", 8'(pend[5]), 8'h00);
    data[5] = 1'b0;
    pulses = 0;
    for (int s = 0; s < 6; s++) begin
      step();
      if (irq[5]) pulses++;
    end
    chk("rise_fall_nopulse", 8'(pulses), 8'h00);
    chk("rise_fall_pend", 8'(pend[5]), 8'h00);
    data[5] = 1'b1;
    for (int s = 0; s < 5; s++) step();
    chk("rise2_pulse_irq", 8'(irq[5]), 8'h01);
    clr[5] = 1'b1;
    step();
    clr[5] = 1'b0;
    chk("rise2_setwins_pend", 8'(pend[5]), 8'h01);
    chk("rise2_after_irq", 8'(irq[5]), 8'h00);

    // falling edge on ch2: 0->1 no pulse, 1->0 exactly one pulse
    data[2] = 1'b1;
    pulses = 0;
    for (int s = 0; s < 8; s++) begin
      step();
      if (irq[2]) pulses++;
    end
    chk("fall_up_pulses", 8'(pulses), 8'h00);
    chk("fall_up_pend", 8'(pend[2]), 8'h00);
    data[2] = 1'b0;
    pulses = 0;
    for (int s = 1; s <= 8; s++) begin
      step();
      if (irq[2]) pulses++;
      if (s == 5) chk("fall_pulse_at5", 8'(irq[2]), 8'h01);
    end
    chk("fall_down_pulses", 8'(pulses), 8'h01);
    chk("fall_down_pend", 8'(pend[2]), 8'h01);
    clr[1] = 1'b1;
    step();
    clr[1] = 1'b0;
    chk("lvllo_clr_ignored", 8'(pend[1]), 8'h01);

    // reset with ch0 mid-debounce (cnt=2) and ch4 pending
    data[4] = 1'b1;
    step();
    step();
    data[0] = 1'b1;
    for (int s = 0; s < 4; s++) step();
    chk("prerst_pend4", 8'(pend[4]), 8'h01);
    chk("prerst_level0", 8'(level[0]), 8'h00);
    rst = 1'b1;
    step();
    chk("midrst_level", level, 8'h00);
    chk("midrst_pend", pend, 8'h00);
    chk("midrst_irq", irq, 8'h02);
    rst = 1'b0;
    for (int s = 1; s <= 4; s++) begin
      step();
      chk($sformatf("postrst%0d_level", s), level, 8'h00);
    end
    step();
    chk("postrst5_level", level, 8'h31);

    // minimal instance: 2-edge latency, then random toggling against a model
    b_data = 1'b1;
    step();
    chk("b_lat1_level", 8'(b_level), 8'h00);
    step();
    chk("b_lat2_level", 8'(b_level), 8'h01);
    chk("b_lat2_irq", 8'(b_irq), 8'h01);
    step();
    chk("b_lat3_irq", 8'(b_irq), 8'h00);
    chk("b_lat3_pend", 8'(b_pend), 8'h01);
    b_data = 1'b0;
    for (int s = 0; s < 3; s++) step();
    chk("b_settle_level", 8'(b_level), 8'h00);
    h0 = 1'b0; h1 = 1'b0; h2 = 1'b0; mp = 1'b1; last_irq = 1'b0;
    for (int n = 0; n < 200; n++) begin
      b_data = 1'($urandom_range(0, 1));
      b_clr  = ($urandom_range(0, 7) == 0);
      mp = last_irq ? 1'b1 : (b_clr ? 1'b0 : mp);
      h2 = h1;
      h1 = h0;
      h0 = b_data;
      step();
      e_irq = h1 & ~h2;
      chk($sformatf("b_rand%0d_level", n), 8'(b_level), 8'(h1));
      chk($sformatf("b_rand%0d_irq", n), 8'(b_irq), 8'(e_irq));
      chk($sformatf("b_rand%0d_pend", n), 8'(b_pend), 8'(mp));
      if (last_irq && b_irq) chk($sformatf("b_rand%0d_double", n), 8'(b_irq), 8'h00);
      last_irq = e_irq;
    end
    b_clr = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/aia_irq_input_conditioner.md
# aia_irq_input_conditioner

Parametrised successor to the plain multi-level synchronizer, used on the interrupt-source inputs of the AIA. It takes `NrChannels` asynchronous wired interrupt lines and passes each through an `NrLevels`-deep synchronizer and a consecutive-sample debounce filter. Each channel is then interpreted by a per-channel source mode (active-high level, active-low level, rising edge or falling edge). The block presents a per-channel interrupt request plus a pending bit that software can clear, ready for the gateway logic.

## Interface
- `NrChannels`, 32: number of independent interrupt lines, ≥1.
- `NrLevels`, 2: synchronizer flops per channel, ≥1. 1 means a single flop, which is still a real register and never a stuck-at.
- `DebounceCycles`, 4: consecutive identical synchronized samples required to accept a new value, ≥1.
- `CntW`, `$clog2(DebounceCycles+1)`: derived, not overridden.

Ports:
- `i_clk` in 1: clock.
- `i_rst` in 1: synchronous, active-high reset.
- `data_i` in `NrChannels`: raw asynchronous interrupt lines.
- `mode_i` in `NrChannels`×2: per-channel `src_mode_e`. Quasi-static.
- `clr_i` in `NrChannels`: pending-clear strobe, one cycle, per channel.
- `level_o` out `NrChannels`: debounced, non-inverted line value `stable_q`.
- `irq_o` out `NrChannels`: mode-interpreted request.
- `pending_o` out `NrChannels`: pending bits.

## Operation
Per channel, every cycle:
- **Sync chain:** `sync_q[0]<=data_i`; `sync_q[k]<=sync_q[k-1]`; `synced=sync_q[NrLevels-1]`.
- **Debounce:** `stable_q`, `cnt_q` (`CntW` bits).
  - `synced==stable_q`: `cnt_q<=0`.
  - Otherwise, if `cnt_q==DebounceCycles-1`: `stable_q<=synced`, `cnt_q<=0`.
  - Otherwise: `cnt_q<=cnt_q+1`.
  - A synced pulse shorter than `DebounceCycles` cycles never reaches `stable_q`. `cnt_q` never exceeds `DebounceCycles-1`, so it does not wrap.
- **History:** `stable_d<=stable_q`. `rise=stable_q&~stable_d`; `fall=~stable_q&stable_d`.
- **`src_mode_e`:**
  - `LVL_HI`(0): `irq_o=stable_q`.
  - `LVL_LO`(1): `irq_o=~stable_q`.
  - `EDGE_RISE`(2): `irq_o=rise`, a one-cycle pulse.
  - `EDGE_FALL`(3): `irq_o=fall`, a one-cycle pulse.
- **Pending, edge modes:** sticky.
  - `pending_q<=1` when `irq_o`.
  - Else `pending_q<=0` when `clr_i`.
  - Set wins over a simultaneous clear.
- **Pending, level modes:** `pending_q<=irq_o`; `clr_i` is ignored (the line must be deasserted at source).
- **Mode change:** takes effect combinationally on `irq_o`. A change between edge and level classes also clears `pending_q` on the next edge, unless the new mode's set condition holds.
  - Edges are derived from `stable_q`/`stable_d`, so a mode change alone never produces an edge pulse.
- **Reset:** `sync_q`, `stable_q`, `stable_d`, `cnt_q` and `pending_q` go to 0. Outputs after reset: `level_o=0`, `pending_o=0`, `irq_o=0`, except `LVL_LO` channels, where `irq_o=1`.
  - Reset asserted mid-debounce discards the count.
  - Reset asserted during an edge pulse drops that pulse.

## Timing
- `data_i` stable before edge E1 → `synced` valid after E(`NrLevels`).
- `stable_q`/`level_o` change after E(`NrLevels`+`DebounceCycles`).
- `irq_o` is valid the same cycle (combinational from registers).
- `pending_o` is valid one edge later: E(`NrLevels`+`DebounceCycles`+1).
- Total input→pending latency: `NrLevels+DebounceCycles+1` cycles.
- `clr_i` high at edge E → `pending_o` low after E.
- Channels are fully independent; no cross-channel ordering is guaranteed beyond identical latency.

## Structure
- **Package `aia_sync_pkg`:** `src_mode_e` enum (2 bits: `LVL_HI`, `LVL_LO`, `EDGE_RISE`, `EDGE_FALL`) and helper `is_edge_mode()`.
- **Sub-module `aia_irq_cond_chan`:** one channel (sync chain, debounce, history, mode mux, pending).
  - The top instantiates it `NrChannels` times in a generate loop and does no logic of its own.

## Test plan
1. **Latency:** `NrLevels=2`, `DebounceCycles=3`, `LVL_HI`; `data_i[0]` 0→1 before E1 and held.
   - `level_o[0]`/`irq_o[0]` go 1 after E5.
   - `pending_o[0]` goes 1 after E6.
   - Deassert → all go 0 with the same latency.
2. **Glitch rejection:** same config; `data_i[3]` high for 2 cycles, then low.
   - `level_o`, `irq_o` and `pending_o` stay 0.
   - A 3-cycle pulse is accepted, and `level_o` is high for exactly 3 cycles.
3. **Edge sticky / clear:** `EDGE_RISE` on ch 5; rising input.
   - `irq_o[5]` is a single one-cycle pulse, and `pending_o[5]` stays 1 indefinitely.
   - `clr_i[5]` pulse → `pending_o` goes 0 next cycle.
   - `clr_i` coincident with a new rise → `pending_o` stays 1.
4. **Active-low / falling edge:** `LVL_LO` on ch 1 from reset → `irq_o[1]=1`, `pending_o[1]=1` after the first edge.
   - `EDGE_FALL` on ch 2: 1→0 input produces one pulse; 0→1 produces none.
   - `clr_i` on the `LVL_LO` channel has no effect.
5. **Reset mid-operation:** assert `i_rst` with ch 0 at `cnt_q=DebounceCycles-1` and ch 4 pending.
   - After the reset edge, all internal state and outputs are 0.
   - The input must then be re-observed for the full `NrLevels+DebounceCycles`.
6. **Parameter corners:** `NrLevels=1`, `DebounceCycles=1`, `NrChannels=1`.
   - Input→`level_o` latency is 2 edges.
   - Random toggling never produces two `irq_o` pulses for one edge-mode transition.
